// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and baud math for the framed UART transmitter (parity state gated by UART_TX_PARITY_EN)
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } tx_state_t;

  // Whole system-clock cycles spent on each line bit.
  function automatic int clk_per_bit(input int clk_hz, input int baudrate);
    return clk_hz / baudrate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - down-counting bit-period timer producing a one-cycle tick
module uart_baud_gen #(
  parameter int CLK_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Count down once per cycle; restart aligns a fresh bit period to the next edge.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= RELOAD;
    end else if (cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  // Tick marks the last cycle of the current bit period.
  assign tick = (cnt == '0);

endmodule

// File: rtl/uart_tx_framed.sv
// rtl/uart_tx_framed.sv - framed UART transmitter; define UART_TX_PARITY_EN to enable the parity bit
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int      CLK_HZ    = 50_000_000,
  parameter int      BAUDRATE  = 38_400,
  parameter int      DATA_BITS = 8,
  parameter int      STOP_BITS = 1,
  parameter parity_t PARITY    = PAR_NONE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic [DATA_BITS-1:0] data,
  output logic                 ready,
  output logic                 busy,
  output logic                 out
);

  localparam int CLK_PER_BIT = clk_per_bit(CLK_HZ, BAUDRATE);

  if (CLK_PER_BIT < 2) begin : g_bad_rate
    $error("uart_tx_framed: CLK_HZ/BAUDRATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_framed: DATA_BITS must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_framed: STOP_BITS must be 1 or 2");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
    $error("uart_tx_framed: illegal PARITY");
  end

  tx_state_t            state;
  logic [DATA_BITS-1:0] shift;
  logic [3:0]           bit_cnt;
  logic                 tick;
  logic                 accept;
`ifdef UART_TX_PARITY_EN
  logic                 par_bit;
`endif

  assign ready  = (state == ST_IDLE);
  assign busy   = !ready;
  assign accept = valid && (state == ST_IDLE);

  uart_baud_gen #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(accept),
    .tick   (tick)
  );

`ifdef UART_TX_PARITY_EN
  // Parity is fixed at acceptance from the latched payload so the line stays register-driven.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bit <= 1'b0;
    end else if (accept) begin
      par_bit <= (^data) ^ (PARITY == PAR_ODD);
    end
  end
`endif

  // Frame sequencer: each state holds the line for one bit period and advances on tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      out     <= 1'b1;
      shift   <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          out <= 1'b1;
          if (valid) begin
            shift   <= data;
            bit_cnt <= '0;
            out     <= 1'b0;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            out     <= shift[0];
            shift   <= {1'b0, shift[DATA_BITS-1:1]};
            bit_cnt <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_cnt == 4'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              if (PARITY != PAR_NONE) begin
                out   <= par_bit;
                state <= ST_PARITY;
              end else begin
                out   <= 1'b1;
                state <= ST_STOP;
              end
`else
              out   <= 1'b1;
              state <= ST_STOP;
`endif
            end else begin
              out     <= shift[0];
              shift   <= {1'b0, shift[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            out     <= 1'b1;
            bit_cnt <= '0;
            state   <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            if (bit_cnt == 4'(STOP_BITS - 1)) begin
              bit_cnt <= '0;
              out     <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        default: begin
          out   <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// tb/tb_uart_tx_framed.sv - scoreboard bench for uart_tx_framed (parity instances under UART_TX_PARITY_EN)
module tb_uart_tx_framed;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       tb_valid;
  logic [8:0] tb_data;
  int         sel;

  int tests  = 0;
  int failed = 0;

  logic exp_q[$];

  logic r8, b8, o8, r5, b5, o5;
  logic mon_out, mon_ready, mon_busy;

  always #5 clk = ~clk;

  uart_tx_framed #(
    .CLK_HZ(16), .BAUDRATE(1), .DATA_BITS(8), .STOP_BITS(1)
  ) dut8 (
    .clk(clk), .rst(rst), .valid(tb_valid && sel == 0), .data(tb_data[7:0]),
    .ready(r8), .busy(b8), .out(o8)
  );

  uart_tx_framed #(
    .CLK_HZ(16), .BAUDRATE(1), .DATA_BITS(5), .STOP_BITS(2)
  ) dut5 (
    .clk(clk), .rst(rst), .valid(tb_valid && sel == 1), .data(tb_data[4:0]),
    .ready(r5), .busy(b5), .out(o5)
  );

`ifdef UART_TX_PARITY_EN
  logic re, be, oe, ro, bo, oo;

  uart_tx_framed #(
    .CLK_HZ(16), .BAUDRATE(1), .DATA_BITS(8), .STOP_BITS(1), .PARITY(PAR_EVEN)
  ) dut_even (
    .clk(clk), .rst(rst), .valid(tb_valid && sel == 2), .data(tb_data[7:0]),
    .ready(re), .busy(be), .out(oe)
  );

  uart_tx_framed #(
    .CLK_HZ(16), .BAUDRATE(1), .DATA_BITS(8), .STOP_BITS(1), .PARITY(PAR_ODD)
  ) dut_odd (
    .clk(clk), .rst(rst), .valid(tb_valid && sel == 3), .data(tb_data[7:0]),
    .ready(ro), .busy(bo), .out(oo)
  );
`endif

  always_comb begin
    mon_out   = o8;
    mon_ready = r8;
    mon_busy  = b8;
    case (sel)
      1: begin mon_out = o5; mon_ready = r5; mon_busy = b5; end
`ifdef UART_TX_PARITY_EN
      2: begin mon_out = oe; mon_ready = re; mon_busy = be; end
      3: begin mon_out = oo; mon_ready = ro; mon_busy = bo; end
`endif
      default: ;
    endcase
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    if (obs != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // par: -1 none, 0 even, 1 odd
  task automatic push_frame(input logic [8:0] d, input int nd, input int ns, input int par);
    logic p;
    p = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < nd; i++) begin
      exp_q.push_back(d[i]);
      p = p ^ d[i];
    end
    if (par >= 0) exp_q.push_back(par == 1 ? ~p : p);
    for (int i = 0; i < ns; i++) exp_q.push_back(1'b1);
  endtask

  task automatic start_frame(input logic [8:0] d);
    tb_valid = 1'b1;
    tb_data  = d;
    @(negedge clk);
    tb_valid = 1'b0;
  endtask

  // Entered at the negedge of the first start-bit cycle.
  task automatic check_frame(input string tag, input int exp_len, input int rst_at, input int poke_at);
    int cyc;
    int low;
    int k;
    logic b;
    int seen;
    cyc = 0;
    low = 0;
    k   = 0;
    while (exp_q.size() > 0) begin
      b    = exp_q.pop_front();
      seen = int'(b);
      for (int i = 0; i < CPB; i++) begin
        if (rst_at >= 0 && cyc == rst_at) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          check({tag, "_rst_out"}, int'(mon_out), 1);
          check({tag, "_rst_ready"}, int'(mon_ready), 1);
          check({tag, "_rst_busy"}, int'(mon_busy), 0);
          exp_q.delete();
          return;
        end
        if (mon_out !== b) seen = int'(mon_out);
        if (!mon_ready) low++;
        if (cyc == poke_at) begin
          tb_valid = 1'b1;
          tb_data  = 9'h077;
        end else if (poke_at >= 0 && cyc == poke_at + 1) begin
          tb_valid = 1'b0;
        end
        cyc++;
        @(negedge clk);
      end
      check($sformatf("%s_bit%0d", tag, k), seen, int'(b));
      k++;
    end
    check({tag, "_len"}, low, exp_len);
    check({tag, "_ready_after"}, int'(mon_ready), 1);
    check({tag, "_out_after"}, int'(mon_out), 1);
    check({tag, "_busy_after"}, int'(mon_busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel      = 0;
    tb_valid = 1'b0;
    tb_data  = '0;
    rst      = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_out", int'(o8), 1);
    check("reset_ready", int'(r8), 1);
    check("reset_busy", int'(b8), 0);

    tb_valid = 1'b1;
    tb_data  = 9'h0A5;
    @(negedge clk);
    rst      = 1'b0;
    tb_valid = 1'b0;
    check("rst_vs_valid_ready", int'(r8), 1);
    check("rst_vs_valid_out", int'(o8), 1);
    @(negedge clk);
    check("rst_vs_valid_ready2", int'(r8), 1);

    push_frame(9'h0A5, 8, 1, -1);
    start_frame(9'h0A5);
    check_frame("a5", 160, -1, -1);

    push_frame(9'h05A, 8, 1, -1);
    start_frame(9'h05A);
    check_frame("poke", 160, -1, 40);

    push_frame(9'h000, 8, 1, -1);
    tb_valid = 1'b1;
    tb_data  = 9'h000;
    @(negedge clk);
    tb_data  = 9'h0FF;
    check_frame("b2b0", 160, -1, -1);
    push_frame(9'h0FF, 8, 1, -1);
    @(negedge clk);
    tb_valid = 1'b0;
    check_frame("b2b1", 160, -1, -1);

    push_frame(9'h0A5, 8, 1, -1);
    start_frame(9'h0A5);
    check_frame("midrst", 160, 50, -1);
    push_frame(9'h03C, 8, 1, -1);
    start_frame(9'h03C);
    check_frame("3c", 160, -1, -1);

    sel = 1;
    @(negedge clk);
    push_frame(9'h013, 5, 2, -1);
    start_frame(9'h013);
    check_frame("d5s2", 128, -1, -1);

`ifdef UART_TX_PARITY_EN
    sel = 2;
    @(negedge clk);
    push_frame(9'h0A5, 8, 1, 0);
    start_frame(9'h0A5);
    check_frame("even", 176, -1, -1);

    sel = 3;
    @(negedge clk);
    push_frame(9'h0A5, 8, 1, 1);
    start_frame(9'h0A5);
    check_frame("odd", 176, -1, -1);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
